// File: rtl/p_fifo_pkg.sv
// rtl/p_fifo_pkg.sv - shared types and width helpers for the parametrised FIFO
package p_fifo_pkg;

  // Pointer / occupancy width: one extra bit above the memory index so that
  // an occupancy of exactly DEPTH is representable and pointers carry a wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/p_fifo_param_if.sv
// rtl/p_fifo_param_if.sv - producer/consumer interface of the parametrised FIFO
interface p_fifo_param_if
  import p_fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
);
  localparam int CNT_W = ptr_w(DEPTH);

  logic              we;
  logic [DATA_W-1:0] data;
  logic              rd;
  logic [DATA_W-1:0] dataout;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output we, data, rd,
    input  dataout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  we, data, rd,
    output dataout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/p_fifo_mem.sv
// rtl/p_fifo_mem.sv - DEPTH x DATA_W register file, one clocked write port, one async read port
module p_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage is intentionally not reset; contents are only meaningful behind the pointers.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/p_fifo_param.sv
// rtl/p_fifo_param.sv - parametrised synchronous FIFO with count, almost flags and error pulses (option: P_FIFO_FWFT_EN)
module p_fifo_param
  import p_fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int AF_MARGIN = 1,
  parameter int AE_MARGIN = 1,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  p_fifo_param_if.slave  bus
);
  localparam int PTR_W = ptr_w(DEPTH);
  localparam logic [PTR_W-1:0] CNT_FULL = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AF_TH    = PTR_W'(DEPTH - AF_MARGIN);
  localparam logic [PTR_W-1:0] AE_TH    = PTR_W'(AE_MARGIN);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              rd_acc, wr_acc;
  logic [DATA_W-1:0] mem_rdata;
  fifo_status_t      status;

  // Wrap bits are carried for pointer-compatible debug views; occupancy comes from count_q.
  logic unused_wrap;
  assign unused_wrap = wr_ptr_q[ADDR_W] ^ rd_ptr_q[ADDR_W];

  // Accept decisions and next-state values; a read frees a slot for a write on the same edge.
  always_comb begin
    rd_acc      = bus.rd && !status.empty;
    wr_acc      = bus.we && (!status.full || rd_acc);
    wr_ptr_d    = wr_acc ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = rd_acc ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d     = count_q + PTR_W'(wr_acc) - PTR_W'(rd_acc);
    overflow_d  = bus.we && !wr_acc;
    underflow_d = bus.rd && status.empty;
  end

  // Pointer, occupancy and error-pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Flags decode only the registered count, so they move the cycle after an accepting edge.
  always_comb begin
    status.full         = (count_q == CNT_FULL);
    status.empty        = (count_q == '0);
    status.almost_full  = (count_q >= AF_TH);
    status.almost_empty = (count_q <= AE_TH);
    status.overflow     = overflow_q;
    status.underflow    = underflow_q;
  end

  p_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (bus.data),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (mem_rdata)
  );

`ifdef P_FIFO_FWFT_EN
  // Head word is presented as soon as it exists; rd only pops it.
  assign bus.dataout = status.empty ? '0 : mem_rdata;
`else
  logic [DATA_W-1:0] dout_q;

  // Registered read: the head captured on the accepting edge, held otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       dout_q <= '0;
    else if (rd_acc) dout_q <= mem_rdata;
  end

  assign bus.dataout = dout_q;
`endif

  assign bus.count        = count_q;
  assign bus.full         = status.full;
  assign bus.empty        = status.empty;
  assign bus.almost_full  = status.almost_full;
  assign bus.almost_empty = status.almost_empty;
  assign bus.overflow     = status.overflow;
  assign bus.underflow    = status.underflow;
endmodule
